// File: rtl/imem_loader_pkg.sv
// ============================================================================
//  Module  : imem_loader_pkg
//  Purpose : Shared types and constants for the boot-time instruction-memory
//            loader: FSM state encoding, frame layout and field widths.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  // Loader FSM states. The frame is two count bytes followed by the payload.
  typedef enum logic [2:0] {
    ST_CNT_LO = 3'd0,  // waiting for count[7:0]
    ST_CNT_HI = 3'd1,  // waiting for count[15:8]
    ST_DATA   = 3'd2,  // receiving instruction bytes
    ST_RUN    = 3'd3,  // image loaded, core released
    ST_ERR    = 3'd4   // oversized image, parked until reset
  } state_t;

  // Header word count width (two header bytes).
  localparam int unsigned COUNT_W = 16;

  // Index of the last byte of a little-endian 32-bit word.
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  // True when a header count does not fit in a memory of the given depth.
  // Compared one bit wider than the count so the full 16-bit range is honoured.
  function automatic logic count_too_big(input logic [COUNT_W-1:0] count,
                                         input logic [COUNT_W:0]   depth);
    return ({1'b0, count} > depth);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
//  Module  : imem_loader_byte_packer
//  Purpose : Assembles a byte stream into little-endian 32-bit words. The first
//            byte of a word lands in bits [7:0]. When the fourth byte arrives
//            the complete word is registered and word_valid pulses for one
//            cycle alongside it.
//  Ports   : clk, reset (async, active-high)
//            clear       - drop any partial word and restart at byte 0
//            byte_valid  - byte_data is consumed this cycle
//            byte_data   - incoming byte
//            word_valid  - 1-cycle pulse, word_data holds a new word
//            word_data   - last assembled word (held between pulses)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  idx_q,        idx_d;
  logic [23:0] shift_q,      shift_d;   // up to three earlier bytes, newest on top
  logic [31:0] word_q,       word_d;
  logic        word_valid_q, word_valid_d;

  always_comb begin
    idx_d        = idx_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;

    if (clear) begin
      idx_d   = 2'd0;
      shift_d = 24'd0;
    end else if (byte_valid) begin
      if (idx_q == LAST_BYTE_IDX) begin
        // Byte 0 has been shifted down to [7:0] by now, so the newest
        // byte simply caps the word.
        word_d       = {byte_data, shift_q};
        word_valid_d = 1'b1;
        idx_d        = 2'd0;
      end else begin
        shift_d = {byte_data, shift_q[23:8]};
        idx_d   = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= 2'd0;
      shift_q      <= 24'd0;
      word_q       <= 32'd0;
      word_valid_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_q;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
//  Module  : imem_loader
//  Purpose : Boot-time program loader for the RV32I core. Receives a framed
//            byte stream (2-byte little-endian word count, then the words LSB
//            first), writes the words to instruction memory from address 0
//            upward and holds the core in reset until the image is complete.
//  Ports   : clk, reset (async, active-high)
//            in_valid/in_data/in_ready      - host byte stream handshake
//            reload                          - restart a load (RUN only)
//            imem_we/imem_waddr/imem_wdata  - imem write port
//            core_reset                      - 1 while loading or in error
//            done                            - image loaded, core running
//            error                           - count > DEPTH, sticky to reset
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned      CNT_EXT_W = COUNT_W + 1;
  localparam logic [COUNT_W:0] DEPTH_EXT = CNT_EXT_W'(DEPTH);

  state_t              state_q, state_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0]   widx_q,  widx_d;

  logic                hs;
  logic [COUNT_W-1:0]  count_full;
  logic                last_word;
  logic                pk_clear;
  logic                pk_valid;
  logic                pk_word_valid;
  logic [31:0]         pk_word;

  assign hs         = in_valid & in_ready;
  // Full header count as it becomes known on the second header byte.
  assign count_full = {in_data, count_q[7:0]};
  // The write currently on the imem port is the final word of the image.
  assign last_word  = (COUNT_W'(widx_q) == (count_q - COUNT_W'(1)));

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pk_clear),
    .byte_valid (pk_valid),
    .byte_data  (in_data),
    .word_valid (pk_word_valid),
    .word_data  (pk_word)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    widx_d   = widx_q;
    pk_clear = 1'b0;
    pk_valid = 1'b0;
    in_ready = 1'b0;

    unique case (state_q)
      ST_CNT_LO: begin
        in_ready = 1'b1;
        if (hs) begin
          count_d[7:0] = in_data;
          state_d      = ST_CNT_HI;
        end
      end

      ST_CNT_HI: begin
        in_ready = 1'b1;
        if (hs) begin
          count_d = count_full;
          if (count_full == '0) begin
            state_d = ST_RUN;
          end else if (count_too_big(count_full, DEPTH_EXT)) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        in_ready = 1'b1;
        pk_valid = hs;
        // The packer's word_valid is the imem write strobe, so the state
        // only moves to RUN on the edge that ends the final write.
        if (pk_word_valid) begin
          if (last_word) begin
            // Index parks on the last address; it is cleared on reload.
            // This keeps it within ADDR_W bits even when count == DEPTH.
            state_d = ST_RUN;
          end else begin
            widx_d = widx_q + ADDR_W'(1);
          end
        end
      end

      ST_RUN: begin
        if (reload) begin
          state_d  = ST_CNT_LO;
          count_d  = '0;
          widx_d   = '0;
          pk_clear = 1'b1;
        end
      end

      ST_ERR: begin
        // Parked until reset.
      end

      default: begin
        state_d = ST_CNT_LO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CNT_LO;
      count_q <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
    end
  end

  assign imem_we    = pk_word_valid;
  assign imem_wdata = pk_word;
  assign imem_waddr = widx_q;
  assign core_reset = (state_q != ST_RUN);
  assign done       = (state_q == ST_RUN);
  assign error      = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module  : tb_imem_loader
//  Purpose : Self-checking bench for imem_loader. Expected imem writes are
//            queued as frames are sent; a monitor collects observed writes,
//            and the two queues are compared after each frame.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every write the DUT performs.
  always @(negedge clk) begin
    if (imem_we === 1'b1) obs_q.push_back({imem_waddr, imem_wdata});
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Status outputs packed as {core_reset, done, error, in_ready, imem_we}.
  function automatic logic [39:0] status();
    return 40'({core_reset, done, error, in_ready, imem_we});
  endfunction

  function automatic logic [31:0] wgen(input int i, input logic [31:0] seed);
    return seed ^ (32'(i) * 32'h9E37_79B9);
  endfunction

  // Starts and ends at a falling edge; leaves in_valid high for back-to-back use.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 20 && in_ready !== 1'b1; t++) @(negedge clk);
    if (in_ready !== 1'b1) begin
      check("in_ready_timeout", 40'(in_ready), 40'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], max_gap);
  endtask

  task automatic send_count(input logic [15:0] c, input int max_gap);
    send_byte(c[7:0], max_gap);
    send_byte(c[15:8], max_gap);
  endtask

  // Sends a complete frame of generated words and queues the expected writes.
  task automatic load(input int n, input logic [31:0] seed, input int max_gap);
    send_count(16'(n), max_gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({8'(i), wgen(i, seed)});
      send_word(wgen(i, seed), max_gap);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    logic [39:0] o;
    logic [39:0] e;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_nwrites"}, 40'(obs_q.size()), 40'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_write"}, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state: core held, ready for header, nothing written.
    check("reset_status", status(), 40'b10010);
    check("reset_wport", {imem_waddr, imem_wdata}, 40'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_status", status(), 40'b10010);
    check("idle_nwrites", 40'(obs_q.size()), 40'd0);

    // Three known instructions, back to back.
    send_count(16'd3, 0);
    exp_q.push_back({8'd0, 32'h0050_0513});
    exp_q.push_back({8'd1, 32'h0000_0593});
    exp_q.push_back({8'd2, 32'h00A0_0613});
    send_word(32'h0050_0513, 0);
    send_word(32'h0000_0593, 0);
    send_word(32'h00A0_0613, 0);
    in_valid = 1'b0;
    // Third write is on the port, core still held.
    check("w3_status", status(), 40'b10011);
    check("w3_wport", {imem_waddr, imem_wdata}, {8'd2, 32'h00A0_0613});
    @(negedge clk);
    check("w3_release", status(), 40'b01000);
    drain_check("cnt3");

    // Reload from RUN, then an empty image.
    pulse_reload();
    check("reload_status", status(), 40'b10010);
    send_count(16'd0, 0);
    in_valid = 1'b0;
    check("cnt0_status", status(), 40'b01000);
    drain_check("cnt0");

    // Oversized image goes to ERR; reload there is ignored.
    pulse_reload();
    send_count(16'd257, 0);
    in_valid = 1'b0;
    check("cnt257_status", status(), 40'b10100);
    pulse_reload();
    repeat (2) @(negedge clk);
    check("err_sticky", status(), 40'b10100);
    drain_check("cnt257");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("err_cleared", status(), 40'b10010);

    // Image exactly filling memory: last address 255, no error.
    load(DEPTH, 32'hDEAD_BEEF, 0);
    drain_check("cnt256");
    check("cnt256_status", status(), 40'b01000);

    // Random gaps in the byte stream must not lose or duplicate bytes.
    pulse_reload();
    load(2, 32'h1234_5678, 3);
    drain_check("gaps");
    check("gaps_status", status(), 40'b01000);

    // Abort a load after five data bytes with an asynchronous reset.
    pulse_reload();
    send_count(16'd2, 0);
    exp_q.push_back({8'd0, 32'hA1B2_C3D4});
    send_word(32'hA1B2_C3D4, 0);
    send_byte(8'h55, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("abort_status", status(), 40'b10010);
    check("abort_wport", {imem_waddr, imem_wdata}, 40'd0);
    @(negedge clk);
    reset = 1'b0;
    drain_check("abort");

    // Fresh single-word image after the abort writes address 0 only.
    load(1, 32'h0BAD_F00D, 0);
    drain_check("cnt1");
    check("cnt1_status", status(), 40'b01000);

    // Reload in RUN: a new image starts again from address 0.
    pulse_reload();
    check("reload2_status", status(), 40'b10010);
    load(2, 32'hCAFE_0001, 1);
    drain_check("reload2");
    check("reload2_done", status(), 40'b01000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
